alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 4-bit combinational lab ALU. Same 8-op set
//  with signed saturating add/sub, generic WIDTH, valid/ready handshake, 1-cycle latency.
//  Adds status flags, a sticky overflow flag, and an accumulator usable as operand A.
//  Sits between switch/stimulus logic and the result display/decode stage.
// PARAMETERS
//  WIDTH  4  operand/result width in bits, two's complement, WIDTH >= 2
//  SAT    1  1: PLUS/SUB saturate on overflow; 0: PLUS/SUB wrap (low WIDTH bits)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      a/b/opcode/acc_sel valid
//  in_ready    out  1      block can accept; = ~out_valid | out_ready (combinational)
//  a           in   WIDTH  signed operand A (ignored when acc_sel=1)
//  b           in   WIDTH  signed operand B
//  opcode      in   3      000 ADD,001 SUB,010 NOT,011 AND,100 OR,101 XOR,110 LT,111 EQ
//  acc_sel     in   1      1: operand A taken from accumulator instead of a
//  clr_sticky  in   1      synchronous clear of ovf_sticky
//  out_valid   out  1      result/flags valid
//  out_ready   in   1      downstream accepts result
//  result      out  WIDTH  registered result
//  flag_z      out  1      result == 0
//  flag_n      out  1      result[WIDTH-1]
//  flag_v      out  1      overflow/underflow of this ADD/SUB (0 for other ops)
//  ovf_sticky  out  1      set by any accepted op with overflow, held until cleared
//  acc         out  WIDTH  accumulator value
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release): out_valid, result, flags, ovf_sticky, acc = 0;
//    in_ready=1 after reset. Reset mid-transfer drops the pending result; no replay.
//  - Accept: in_valid & in_ready at rising edge. Next cycle: out_valid=1, result/flags/acc
//    updated. Latency 1; throughput 1/cycle while out_ready=1.
//  - Output stall: out_valid & ~out_ready -> result, flags, out_valid held stable; in_ready=0.
//    Simultaneous pop and accept: new result replaces old in the same edge.
//  - out_valid clears when popped with no new accept.
//  - Operand A: opA = acc_sel ? acc : a. acc <= result on every accept (all opcodes).
//    Back-to-back acc_sel ops use the acc value written by the previous accept.
//  - ADD/SUB: sign-extend to WIDTH+1, compute t. Overflow when t[WIDTH]=0, t[WIDTH-1]=1:
//    SAT=1 -> 2^(WIDTH-1)-1. Underflow when t[WIDTH]=1, t[WIDTH-1]=0:
//    SAT=1 -> -2^(WIDTH-1). SAT=0 -> t[WIDTH-1:0]. Both cases set flag_v=1.
//  - NOT: ~opA. AND/OR/XOR: bitwise opA,b. LT: result = 1 if opA < b (signed), else 0,
//    zero-extended. EQ: 1 if opA == b, else 0, zero-extended.
//  - flag_z/flag_n are computed from the final (saturated or wrapped) result.
//  - ovf_sticky: set on accept with flag_v=1; cleared by clr_sticky. Same-cycle set and
//    clear -> set wins. clr_sticky acts regardless of handshake state.
//  - Unused opcode space: none; all 8 codes defined.
// TESTING
//  1 W=4,SAT=1: ADD 7+1 -> result 4'b0111, flag_v=1, ovf_sticky=1; SUB -8-1 -> 4'b1000,
//    flag_v=1, flag_n=1.
//  2 W=4,SAT=0: ADD 7+1 -> 4'b1000, flag_v=1, flag_n=1; ADD -3+3 -> 0, flag_z=1, flag_v=0.
//  3 Backpressure: out_ready=0 for 3 cycles after op1 -> result stable, in_ready=0, op2 held
//    at input; out_ready=1 -> op1 popped, op2 appears next cycle, no loss or duplicate.
//  4 Accumulator W=4,SAT=1: from reset, 4x ADD acc_sel=1 b=3 -> results 3,6,7,7;
//    flag_v=1 on 3rd and 4th; acc=7.
//  5 Compare/sticky: LT -8<7 -> 1; EQ 5==5 -> 1; EQ 5==4 -> 0. Overflow accept with
//    clr_sticky=1 in the same cycle -> ovf_sticky=1; clr_sticky alone next cycle -> 0.
//  6 W=8: ADD 100+50 -> 127, flag_v=1. Assert rst_n low with out_valid=1 -> out_valid, acc,
//    ovf_sticky=0 immediately; in_ready=1.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered 8-op signed ALU with handshake, flags, sticky overflow and accumulator
//
// Purpose:
//   One-stage pipelined ALU. An operation is accepted when in_valid & in_ready
//   at a rising edge. The result, flags and accumulator update on that edge and
//   are presented with out_valid on the following cycle. PLUS/SUB saturate
//   (SAT=1) or wrap (SAT=0) on signed overflow.
//
// Parameters:
//   WIDTH       operand/result width, two's complement, >= 2
//   SAT         1: ADD/SUB saturate, 0: ADD/SUB wrap
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operands/opcode valid
//   in_ready    block can accept (~out_valid | out_ready)
//   a, b        signed operands (a ignored when acc_sel=1)
//   opcode      000 ADD,001 SUB,010 NOT,011 AND,100 OR,101 XOR,110 LT,111 EQ
//   acc_sel     take operand A from the accumulator
//   clr_sticky  clear ovf_sticky
//   out_valid   result/flags valid
//   out_ready   downstream accepts result
//   result      registered result
//   flag_z      result == 0
//   flag_n      result sign bit
//   flag_v      ADD/SUB overflow or underflow
//   ovf_sticky  set by any accepted overflowing op, held until cleared
//   acc         accumulator (last accepted result)
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             acc_sel,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   t;
  logic             ovf;
  logic             unf;
  logic [WIDTH-1:0] res_nxt;
  logic             v_nxt;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    op_a = acc_sel ? acc : a;
    // One extra sign bit makes signed overflow visible as a mismatch of the
    // top two bits of the sum/difference.
    if (opcode == OP_SUB) begin
      t = {op_a[WIDTH-1], op_a} - {b[WIDTH-1], b};
    end else begin
      t = {op_a[WIDTH-1], op_a} + {b[WIDTH-1], b};
    end
    ovf = ~t[WIDTH] & t[WIDTH-1];
    unf = t[WIDTH] & ~t[WIDTH-1];

    res_nxt = '0;
    v_nxt   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        v_nxt = ovf | unf;
        if (SAT && ovf) begin
          res_nxt = MAX_POS;
        end else if (SAT && unf) begin
          res_nxt = MIN_NEG;
        end else begin
          res_nxt = t[WIDTH-1:0];
        end
      end
      OP_NOT: res_nxt = ~op_a;
      OP_AND: res_nxt = op_a & b;
      OP_OR:  res_nxt = op_a | b;
      OP_XOR: res_nxt = op_a ^ b;
      OP_LT:  res_nxt = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(b))};
      OP_EQ:  res_nxt = {{(WIDTH-1){1'b0}}, (op_a == b)};
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else begin
      // A pop and a new accept on the same edge simply overwrite the
      // output register; a pop alone empties it.
      if (accept) begin
        out_valid <= 1'b1;
        result    <= res_nxt;
        flag_z    <= (res_nxt == '0);
        flag_n    <= res_nxt[WIDTH-1];
        flag_v    <= v_nxt;
        acc       <= res_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Setting has priority so an overflow is never lost to a same-cycle clear.
      if (accept && v_nxt) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       acc_sel;
  logic       clr_sticky;
  logic [2:0] opcode;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic       r0_rdy, r0_ov, r0_z, r0_n, r0_v, r0_stk;
  logic [3:0] r0_res, r0_acc;
  logic       r1_rdy, r1_ov, r1_z, r1_n, r1_v, r1_stk;
  logic [3:0] r1_res, r1_acc;
  logic       r2_rdy, r2_ov, r2_z, r2_n, r2_v, r2_stk;
  logic [7:0] r2_res, r2_acc;

  alu_pipe #(.WIDTH(4), .SAT(1'b1)) u_w4_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_rdy),
    .a(a4), .b(b4), .opcode(opcode), .acc_sel(acc_sel), .clr_sticky(clr_sticky),
    .out_valid(r0_ov), .out_ready(out_ready), .result(r0_res),
    .flag_z(r0_z), .flag_n(r0_n), .flag_v(r0_v), .ovf_sticky(r0_stk), .acc(r0_acc)
  );

  alu_pipe #(.WIDTH(4), .SAT(1'b0)) u_w4_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_rdy),
    .a(a4), .b(b4), .opcode(opcode), .acc_sel(acc_sel), .clr_sticky(clr_sticky),
    .out_valid(r1_ov), .out_ready(out_ready), .result(r1_res),
    .flag_z(r1_z), .flag_n(r1_n), .flag_v(r1_v), .ovf_sticky(r1_stk), .acc(r1_acc)
  );

  alu_pipe #(.WIDTH(8), .SAT(1'b1)) u_w8_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2_rdy),
    .a(a8), .b(b8), .opcode(opcode), .acc_sel(acc_sel), .clr_sticky(clr_sticky),
    .out_valid(r2_ov), .out_ready(out_ready), .result(r2_res),
    .flag_z(r2_z), .flag_n(r2_n), .flag_v(r2_v), .ovf_sticky(r2_stk), .acc(r2_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference model state, one slot per instance (0: W4 sat, 1: W4 wrap, 2: W8 sat).
  // All instances share the handshake inputs, so one valid bit covers all three.
  bit m_valid;
  int m_res[3];
  int m_v[3];
  int m_acc[3];
  int m_stk[3];

  function automatic int cw(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int cs(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int sx(input int u, input int w);
    return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
  endfunction

  // Arithmetic-level ALU: operands given as unsigned w-bit codes.
  task automatic model_op(input int w, input int sat, input int op, input int x, input int y,
                          output int r, output int v);
    int sa, sb, t, mx, mn, full;
    sa   = sx(x, w);
    sb   = sx(y, w);
    mx   = (1 << (w - 1)) - 1;
    mn   = -(1 << (w - 1));
    full = (1 << w) - 1;
    v    = 0;
    case (op)
      0: t = sa + sb;
      1: t = sa - sb;
      2: t = full - x;
      3: t = x & y;
      4: t = x | y;
      5: t = x ^ y;
      6: t = (sa < sb) ? 1 : 0;
      default: t = (x == y) ? 1 : 0;
    endcase
    if (op < 2) begin
      if (t > mx) begin
        v = 1;
        t = (sat != 0) ? mx : t - (1 << w);
      end else if (t < mn) begin
        v = 1;
        t = (sat != 0) ? mn : t + (1 << w);
      end
    end
    r = t & full;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_res[k] = 0;
      m_v[k]   = 0;
      m_acc[k] = 0;
      m_stk[k] = 0;
    end
  endtask

  task automatic model_step();
    bit acc_ok;
    int x, y, r, v;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc_ok = in_valid && (!m_valid || out_ready);
      for (int k = 0; k < 3; k++) begin
        if (acc_ok) begin
          x = acc_sel ? m_acc[k] : ((k == 2) ? int'(a8) : int'(a4));
          y = (k == 2) ? int'(b8) : int'(b4);
          model_op(cw(k), cs(k), int'(opcode), x, y, r, v);
          m_res[k] = r;
          m_v[k]   = v;
          m_acc[k] = r;
          if (v != 0) m_stk[k] = 1;
          else if (clr_sticky) m_stk[k] = 0;
        end else if (clr_sticky) begin
          m_stk[k] = 0;
        end
      end
      if (acc_ok) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic check_inst(input int k, input int rdy, input int ov, input int res,
                            input int z, input int n, input int v, input int stk,
                            input int acc);
    int w;
    w = cw(k);
    check($sformatf("u%0d in_ready", k), rdy, (!m_valid || out_ready) ? 1 : 0);
    check($sformatf("u%0d out_valid", k), ov, int'(m_valid));
    if (m_valid) begin
      check($sformatf("u%0d result", k), res, m_res[k]);
      check($sformatf("u%0d flag_z", k), z, (m_res[k] == 0) ? 1 : 0);
      check($sformatf("u%0d flag_n", k), n, (m_res[k] >> (w - 1)) & 1);
      check($sformatf("u%0d flag_v", k), v, m_v[k]);
    end
    check($sformatf("u%0d acc", k), acc, m_acc[k]);
    check($sformatf("u%0d ovf_sticky", k), stk, m_stk[k]);
  endtask

  task automatic compare_all();
    check_inst(0, r0_rdy, r0_ov, r0_res, r0_z, r0_n, r0_v, r0_stk, r0_acc);
    check_inst(1, r1_rdy, r1_ov, r1_res, r1_z, r1_n, r1_v, r1_stk, r1_acc);
    check_inst(2, r2_rdy, r2_ov, r2_res, r2_z, r2_n, r2_v, r2_stk, r2_acc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input int op, input bit asel, input int xa4, input int xb4,
                       input int xa8, input int xb8, input bit clr, input bit ordy);
    in_valid   = v;
    opcode     = 3'(op);
    acc_sel    = asel;
    a4         = 4'(xa4);
    b4         = 4'(xb4);
    a8         = 8'(xa8);
    b8         = 8'(xb8);
    clr_sticky = clr;
    out_ready  = ordy;
  endtask

  // Called at a negedge: asserts reset, checks the asynchronous clear,
  // holds reset across one edge and releases it away from the edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset in_ready", r0_rdy, 1);
    check("reset result", r0_res, 0);
    check("reset acc", r0_acc, 0);
    rst_n = 1'b1;
    tick();

    // Saturate vs wrap on positive overflow, and W=8 saturation.
    drive(1, 0, 0, 7, 1, 100, 50, 0, 1);
    tick();
    check("sat add 7+1 result", r0_res, 7);
    check("sat add 7+1 flag_v", r0_v, 1);
    check("sat add 7+1 sticky", r0_stk, 1);
    check("wrap add 7+1 result", r1_res, 8);
    check("wrap add 7+1 flag_v", r1_v, 1);
    check("wrap add 7+1 flag_n", r1_n, 1);
    check("w8 add 100+50 result", r2_res, 127);
    check("w8 add 100+50 flag_v", r2_v, 1);

    drive(1, 1, 0, 8, 1, 0, 0, 0, 1);
    tick();
    check("sat sub -8-1 result", r0_res, 8);
    check("sat sub -8-1 flag_v", r0_v, 1);
    check("sat sub -8-1 flag_n", r0_n, 1);

    drive(1, 0, 0, 13, 3, 0, 0, 0, 1);
    tick();
    check("wrap add -3+3 result", r1_res, 0);
    check("wrap add -3+3 flag_z", r1_z, 1);
    check("wrap add -3+3 flag_v", r1_v, 0);

    // Reset while a result is pending.
    check("pre-reset out_valid", r2_ov, 1);
    pulse_reset();
    check("post-reset w8 out_valid", r2_ov, 0);
    check("post-reset w8 in_ready", r2_rdy, 1);

    // Accumulator chain from reset.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 3, 0, 3, 0, 1);
      tick();
      check($sformatf("acc chain %0d result", i), r0_res, (i == 0) ? 3 : (i == 1) ? 6 : 7);
      check($sformatf("acc chain %0d flag_v", i), r0_v, (i >= 2) ? 1 : 0);
    end
    check("acc chain final acc", r0_acc, 7);

    // Compares and sticky priority.
    drive(1, 6, 0, 8, 7, 0, 0, 0, 1);
    tick();
    check("lt -8<7", r0_res, 1);
    drive(1, 7, 0, 5, 5, 0, 0, 0, 1);
    tick();
    check("eq 5==5", r0_res, 1);
    drive(1, 7, 0, 5, 4, 0, 0, 1, 1);
    tick();
    check("eq 5==4", r0_res, 0);
    check("sticky cleared", r0_stk, 0);
    drive(1, 0, 0, 7, 1, 0, 0, 1, 1);
    tick();
    check("sticky set beats clear", r0_stk, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check("sticky clear alone", r0_stk, 0);
    check("pop empties output", r0_ov, 0);

    // Backpressure: op1 stalls for 3 cycles while op2 waits at the input.
    drive(1, 0, 0, 1, 2, 1, 2, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 2, 2, 2, 2, 0, 0);
      tick();
      check($sformatf("stall %0d result", i), r0_res, 3);
      check($sformatf("stall %0d in_ready", i), r0_rdy, 0);
    end
    drive(1, 0, 0, 2, 2, 2, 2, 0, 1);
    tick();
    check("after stall op2 result", r0_res, 4);
    check("after stall out_valid", r0_ov, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("after stall drained", r0_ov, 0);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
